id_ex_stage: RTL and testbench

//  ID->EX pipeline register plus operand-select stage directly upstream of the ALU.
//  - Captures decoded instruction fields under a valid/ready handshake.
//  - Resolves RAW hazards by forwarding from the MEM and WB stages.
//  - Drives the ALU's a/b operands and 3-bit alu_ctrl (000 add, 001 sub, 010 and, 011 or).

---
 rtl/id_ex_stage.sv | 153 +++++++++++++++
 tb/tb_id_ex_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with ALU operand select, alu_ctrl decode and MEM/WB forwarding.
// Define ID_EX_FWD_EN to enable forwarding and stall refresh; otherwise held regfile data is used.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_use_imm,
    input  logic [1:0]        id_alu_op,
    input  logic [2:0]        id_funct3,
    input  logic              id_funct7_5,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [2:0]        alu_ctrl,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_illegal,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_result
);

    logic              valid_q;
    logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
    logic [XLEN-1:0]   rs1_data_q, rs2_data_q, imm_q;
    logic              use_imm_q, reg_write_q, illegal_q;
    logic [2:0]        ctrl_q;

    logic              load;
    logic              stall;
    logic [2:0]        dec_ctrl;
    logic              dec_illegal;
    logic [XLEN-1:0]   opnd_a, opnd_b;

    assign id_ready = !valid_q || ex_ready;
    // A flush drops the offered instruction, so none of its fields are captured.
    assign load     = id_valid && id_ready && !flush;
    assign stall    = valid_q && !ex_ready;

    always_comb begin
        dec_ctrl    = 3'b000;
        dec_illegal = 1'b0;
        case (id_alu_op)
            2'b00: dec_ctrl = 3'b000;
            2'b01: dec_ctrl = 3'b001;
            2'b10: begin
                case (id_funct3)
                    3'b000:  dec_ctrl = (id_funct7_5 && !id_use_imm) ? 3'b001 : 3'b000;
                    3'b111:  dec_ctrl = 3'b010;
                    3'b110:  dec_ctrl = 3'b011;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

`ifdef ID_EX_FWD_EN
    // MEM is the younger producer, so it wins over WB; x0 is hardwired and never forwarded.
    always_comb begin
        opnd_a = rs1_data_q;
        if (mem_reg_write && (mem_rd == rs1_q) && (rs1_q != '0))
            opnd_a = mem_result;
        else if (wb_reg_write && (wb_rd == rs1_q) && (rs1_q != '0))
            opnd_a = wb_result;
    end

    always_comb begin
        opnd_b = rs2_data_q;
        if (mem_reg_write && (mem_rd == rs2_q) && (rs2_q != '0))
            opnd_b = mem_result;
        else if (wb_reg_write && (wb_rd == rs2_q) && (rs2_q != '0))
            opnd_b = wb_result;
    end
`else
    assign opnd_a = rs1_data_q;
    assign opnd_b = rs2_data_q;

    logic unused_fwd;
    assign unused_fwd = ^{mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
                          rs1_q, rs2_q, stall};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
        end else if (valid_q && ex_ready) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q       <= '0;
            rs2_q       <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            ctrl_q      <= 3'b000;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (load) begin
            rs1_q       <= id_rs1;
            rs2_q       <= id_rs2;
            rs1_data_q  <= id_rs1_data;
            rs2_data_q  <= id_rs2_data;
            imm_q       <= id_imm;
            use_imm_q   <= id_use_imm;
            ctrl_q      <= dec_ctrl;
            rd_q        <= id_rd;
            reg_write_q <= id_reg_write && !dec_illegal;
            illegal_q   <= dec_illegal;
        end
`ifdef ID_EX_FWD_EN
        // Keep a producer that retires from WB while we are stalled.
        else if (stall) begin
            rs1_data_q <= opnd_a;
            rs2_data_q <= opnd_b;
        end
`endif
    end

    assign ex_valid     = valid_q;
    assign alu_a        = opnd_a;
    assign alu_b        = use_imm_q ? imm_q : opnd_b;
    assign alu_ctrl     = ctrl_q;
    assign ex_rd        = rd_q;
    assign ex_reg_write = reg_write_q;
    assign ex_illegal   = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; forwarding expectations follow ID_EX_FWD_EN.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, flush, id_valid, id_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd, ex_rd, mem_rd, wb_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, alu_a, alu_b, mem_result, wb_result;
    logic        id_use_imm, id_funct7_5, id_reg_write, ex_ready, ex_valid;
    logic [1:0]  id_alu_op;
    logic [2:0]  id_funct3, alu_ctrl;
    logic        ex_reg_write, ex_illegal, mem_reg_write, wb_reg_write;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op), .id_funct3(id_funct3),
        .id_funct7_5(id_funct7_5), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ctrl(alu_ctrl), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Offer one instruction for a single clock edge; returns 1 ns after the edge.
    task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] imm, input logic use_imm,
                         input logic [1:0] op, input logic [2:0] f3, input logic f75,
                         input logic [4:0] rd, input logic rw);
        id_rs1 = rs1; id_rs2 = rs2; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        id_use_imm = use_imm; id_alu_op = op; id_funct3 = f3; id_funct7_5 = f75;
        id_rd = rd; id_reg_write = rw; id_valid = 1'b1;
        @(posedge clk); #1;
        id_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
        id_rs1 = '0; id_rs2 = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_use_imm = 1'b0; id_alu_op = 2'b00; id_funct3 = 3'b000; id_funct7_5 = 1'b0;
        id_rd = '0; id_reg_write = 1'b0;
        mem_rd = '0; mem_reg_write = 1'b0; mem_result = '0;
        wb_rd = '0; wb_reg_write = 1'b0; wb_result = '0;

        // reset state
        #12;
        check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
        check("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
        check("rst_ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
        check("rst_ex_illegal", {31'd0, ex_illegal}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        step();
        check("rst_id_ready", {31'd0, id_ready}, 32'd1);

        // decode
        offer(5'd1, 5'd2, 32'h11, 32'h22, 32'h99, 1'b0, 2'b10, 3'b000, 1'b1, 5'd3, 1'b1);
        check("dec_sub_valid", {31'd0, ex_valid}, 32'd1);
        check("dec_sub_ctrl", {29'd0, alu_ctrl}, 32'd1);
        check("dec_sub_alu_a", alu_a, 32'h11);
        check("dec_sub_alu_b", alu_b, 32'h22);
        check("dec_sub_rd", {27'd0, ex_rd}, 32'd3);
        check("dec_sub_rw", {31'd0, ex_reg_write}, 32'd1);
        offer(5'd1, 5'd2, 32'h11, 32'h22, 32'h99, 1'b1, 2'b10, 3'b000, 1'b1, 5'd3, 1'b1);
        check("dec_addi_ctrl", {29'd0, alu_ctrl}, 32'd0);
        check("dec_addi_alu_b", alu_b, 32'h99);
        offer(5'd1, 5'd2, 32'h11, 32'h22, 32'h99, 1'b0, 2'b10, 3'b111, 1'b0, 5'd3, 1'b1);
        check("dec_and_ctrl", {29'd0, alu_ctrl}, 32'd2);
        offer(5'd1, 5'd2, 32'h11, 32'h22, 32'h99, 1'b0, 2'b10, 3'b110, 1'b0, 5'd3, 1'b1);
        check("dec_or_ctrl", {29'd0, alu_ctrl}, 32'd3);
        check("dec_or_illegal", {31'd0, ex_illegal}, 32'd0);
        offer(5'd1, 5'd2, 32'h11, 32'h22, 32'h99, 1'b0, 2'b10, 3'b001, 1'b0, 5'd3, 1'b1);
        check("dec_f3_001_illegal", {31'd0, ex_illegal}, 32'd1);
        check("dec_f3_001_ctrl", {29'd0, alu_ctrl}, 32'd0);
        check("dec_f3_001_rw", {31'd0, ex_reg_write}, 32'd0);
        offer(5'd1, 5'd2, 32'h11, 32'h22, 32'h99, 1'b0, 2'b11, 3'b111, 1'b0, 5'd3, 1'b1);
        check("dec_op11_illegal", {31'd0, ex_illegal}, 32'd1);
        check("dec_op11_ctrl", {29'd0, alu_ctrl}, 32'd0);
        offer(5'd1, 5'd2, 32'h11, 32'h22, 32'h99, 1'b0, 2'b01, 3'b111, 1'b0, 5'd3, 1'b0);
        check("dec_op01_ctrl", {29'd0, alu_ctrl}, 32'd1);
        check("dec_op01_illegal", {31'd0, ex_illegal}, 32'd0);
        step();
        check("consume_ex_valid", {31'd0, ex_valid}, 32'd0);

        // forwarding, combinational on the held rs1
        offer(5'd5, 5'd6, 32'h1111, 32'h2222, 32'h0, 1'b0, 2'b00, 3'b000, 1'b0, 5'd9, 1'b1);
        mem_rd = 5'd5; mem_reg_write = 1'b1; mem_result = 32'hAAAA;
        wb_rd = 5'd5; wb_reg_write = 1'b1; wb_result = 32'hBBBB;
        #1;
        check("fwd_mem_wins", alu_a, FWD ? 32'hAAAA : 32'h1111);
        check("fwd_b_no_match", alu_b, 32'h2222);
        mem_reg_write = 1'b0; #1;
        check("fwd_wb", alu_a, FWD ? 32'hBBBB : 32'h1111);
        mem_rd = 5'd0; mem_reg_write = 1'b1; wb_rd = 5'd0;
        offer(5'd0, 5'd6, 32'h3333, 32'h2222, 32'h0, 1'b0, 2'b00, 3'b000, 1'b0, 5'd9, 1'b1);
        check("fwd_x0_never", alu_a, 32'h3333);
        mem_reg_write = 1'b0; wb_reg_write = 1'b0; wb_rd = 5'd0;
        step();

        // stall refresh: WB producer visible only in the first stall cycle
        ex_ready = 1'b0;
        offer(5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 3'b000, 1'b0, 5'd4, 1'b1);
        wb_rd = 5'd7; wb_reg_write = 1'b1; wb_result = 32'h1234; #1;
        check("stall_c1_alu_b", alu_b, FWD ? 32'h1234 : 32'h0);
        check("stall_id_ready", {31'd0, id_ready}, 32'd0);
        step();
        wb_reg_write = 1'b0; wb_result = 32'h0; #1;
        check("stall_c2_alu_b", alu_b, FWD ? 32'h1234 : 32'h0);
        step();
        check("stall_c3_alu_b", alu_b, FWD ? 32'h1234 : 32'h0);
        check("stall_ex_valid", {31'd0, ex_valid}, 32'd1);
        ex_ready = 1'b1;
        step();
        check("stall_release", {31'd0, ex_valid}, 32'd0);

        // back-to-back: one new entry per cycle
        ex_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_data = 32'h100 + i; id_rs2_data = 32'h0;
            id_imm = 32'h50 + i; id_use_imm = 1'b1; id_alu_op = 2'b00; id_funct3 = 3'b000;
            id_funct7_5 = 1'b0; id_rd = 5'(i + 1); id_reg_write = 1'b1; id_valid = 1'b1;
            #1;
            check("b2b_id_ready", {31'd0, id_ready}, 32'd1);
            step();
            check("b2b_ex_valid", {31'd0, ex_valid}, 32'd1);
            check("b2b_alu_a", alu_a, 32'h100 + i);
            check("b2b_alu_b", alu_b, 32'h50 + i);
            check("b2b_ex_rd", {27'd0, ex_rd}, i + 1);
        end
        id_valid = 1'b0;

        // flush beats a same-cycle load
        id_rd = 5'd31; id_rs1_data = 32'hDEAD; id_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; id_valid = 1'b0;
        check("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("flush_rd_not_loaded", {27'd0, ex_rd}, 32'd8);
        step();
        check("flush_stays_empty", {31'd0, ex_valid}, 32'd0);

        // asynchronous reset mid-stream
        offer(5'd3, 5'd4, 32'h77, 32'h88, 32'h0, 1'b0, 2'b10, 3'b110, 1'b0, 5'd12, 1'b1);
        check("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
        #2 rst_n = 1'b0; #1;
        check("mid_rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("mid_rst_alu_a", alu_a, 32'd0);
        check("mid_rst_alu_b", alu_b, 32'd0);
        check("mid_rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        step();
        check("post_rst_id_ready", {31'd0, id_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
